// File: rtl/counter_pkg.sv
// counter_pkg
// Shared constants and helpers for the up/down modulus counter.
//   DIR_UP / DIR_DOWN    : encodings of the dir input
//   MODE_WRAP / MODE_SAT : encodings of the sat input
//   clamp()              : min(value, limit), used by the load path and by the
//                          runtime-max handling in the next-state logic
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the helper supports; callers zero-extend into it and
    // truncate the result back to their own WIDTH.
    localparam int CNT_MAX_W = 32;

    function automatic logic [CNT_MAX_W-1:0] clamp(
        input logic [CNT_MAX_W-1:0] value,
        input logic [CNT_MAX_W-1:0] limit
    );
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next
// Combinational next-count logic for counter_updown_mod.
// Ports:
//   q        in  WIDTH  current count
//   dir      in  1      1 = up, 0 = down
//   sat      in  1      1 = saturate at boundary, 0 = wrap
//   max_val  in  WIDTH  terminal value (range 0..max_val)
//   q_next   out WIDTH  count to load if an enabled count happens this edge
//   boundary out 1      current count sits on the terminal value for dir
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             sat,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] q_next,
    output logic             boundary
);

    logic [WIDTH-1:0] q_clamped;

    // Pulls q back into range if max_val was lowered below it at runtime.
    assign q_clamped = WIDTH'(clamp(CNT_MAX_W'(q), CNT_MAX_W'(max_val)));

    always_comb begin
        q_next   = q;
        boundary = 1'b0;
        if (dir == DIR_UP) begin
            // ">=" rather than "==" so a count stranded above a lowered
            // max_val still terminates instead of running to 2**WIDTH-1.
            boundary = (q >= max_val);
            if (boundary) begin
                q_next = (sat == MODE_SAT) ? q_clamped : '0;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end else begin
            boundary = (q == '0);
            if (boundary) begin
                q_next = (sat == MODE_SAT) ? q : max_val;
            end else begin
                q_next = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod
// General-purpose up/down counter with runtime modulus, parallel load,
// wrap/saturate mode, registered terminal-count pulse and sticky overflow.
// Ports:
//   clk      in  1      rising-edge clock
//   clr      in  1      asynchronous active-high reset
//   ce       in  1      count enable
//   load     in  1      synchronous load strobe (beats ce)
//   d        in  WIDTH  load value, clamped to max_val
//   dir      in  1      1 = up, 0 = down
//   max_val  in  WIDTH  terminal value
//   sat      in  1      1 = saturate, 0 = wrap
//   ovf_clr  in  1      synchronous clear of ovf
//   q        out WIDTH  current count
//   tc       out 1      one-cycle pulse after each boundary event
//   ovf      out 1      sticky, set by a boundary event in saturate mode
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_load;
    logic             boundary;
    logic             count_evt;
    logic             bnd_evt;
    logic             ovf_set;

    counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .q       (q),
        .dir     (dir),
        .sat     (sat),
        .max_val (max_val),
        .q_next  (q_next),
        .boundary(boundary)
    );

    assign q_load    = WIDTH'(clamp(CNT_MAX_W'(d), CNT_MAX_W'(max_val)));
    assign count_evt = ce & ~load;
    assign bnd_evt   = count_evt & boundary;
    assign ovf_set   = bnd_evt & (sat == MODE_SAT);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q   <= RESET_VAL;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (load) begin
                q <= q_load;
            end else if (ce) begin
                q <= q_next;
            end
            tc  <= bnd_evt;
            // Set has priority over a same-edge clear; load leaves ovf alone.
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod
// Directed-vector bench for counter_updown_mod (WIDTH=4, RESET_VAL=0).
module tb_counter_updown_mod;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         ce = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic         dir = 1'b1;
    logic [W-1:0] max_val = 4'd9;
    logic         sat = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         ovf;

    int checks = 0;
    int fails  = 0;
    int vec_id = 0;

    // Expected {q, tc, ovf} after the edge following each issued vector.
    logic [W+1:0] exp_q[$];

    counter_updown_mod #(
        .WIDTH    (W),
        .RESET_VAL(4'd0)
    ) dut (
        .clk    (clk),
        .clr    (clr),
        .ce     (ce),
        .load   (load),
        .d      (d),
        .dir    (dir),
        .max_val(max_val),
        .sat    (sat),
        .ovf_clr(ovf_clr),
        .q      (q),
        .tc     (tc),
        .ovf    (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // Drives one vector on the falling edge, records the expected response,
    // then lets the rising edge sample it.
    task automatic step(
        input logic         c,
        input logic         l,
        input logic [W-1:0] dd,
        input logic         dr,
        input logic [W-1:0] mv,
        input logic         s,
        input logic         oc,
        input logic [W-1:0] e_q,
        input logic         e_tc,
        input logic         e_ovf
    );
        @(negedge clk);
        ce      = c;
        load    = l;
        d       = dd;
        dir     = dr;
        max_val = mv;
        sat     = s;
        ovf_clr = oc;
        exp_q.push_back({e_q, e_tc, e_ovf});
        @(posedge clk);
    endtask

    // Immediate check, used where no clock edge is involved (async clear).
    task automatic check_now(
        input string        name,
        input logic [W-1:0] e_q,
        input logic         e_tc,
        input logic         e_ovf
    );
        checks++;
        if ({q, tc, ovf} !== {e_q, e_tc, e_ovf}) begin
            fails++;
            $display("FAIL %s: got q=%0d tc=%0b ovf=%0b, expected q=%0d tc=%0b ovf=%0b",
                     name, q, tc, ovf, e_q, e_tc, e_ovf);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [W+1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                vec_id++;
                checks++;
                if ({q, tc, ovf} !== exp) begin
                    fails++;
                    $display("FAIL vec%0d: got q=%0d tc=%0b ovf=%0b, expected q=%0d tc=%0b ovf=%0b",
                             vec_id, q, tc, ovf, exp[W+1:2], exp[1], exp[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        // reset state
        repeat (2) @(negedge clk);
        check_now("reset", 4'd0, 1'b0, 1'b0);

        // up count, max 9, wrap: 1..9, 0 (tc), 1, 2
        @(negedge clk);
        clr = 1'b0;
        for (int i = 1; i <= 9; i++)
            step(1, 0, 0, 1, 9, 0, 0, W'(i), 0, 0);
        step(1, 0, 0, 1, 9, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 9, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 9, 0, 0, 2, 0, 0);

        // down, max 5, wrap from 0
        step(0, 1, 0, 1, 9, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 0, 5, 1, 0);
        step(1, 0, 0, 0, 5, 0, 0, 4, 0, 0);
        step(1, 0, 0, 0, 5, 0, 0, 3, 0, 0);
        // saturate going down
        step(1, 0, 0, 0, 5, 1, 0, 2, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0, 1, 1);
        step(1, 0, 0, 0, 5, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 5, 1, 1, 0, 0, 0);

        // load clamps to max_val and leaves ovf alone; load beats ce
        step(1, 0, 0, 0, 9, 1, 0, 0, 1, 1);
        step(0, 1, 13, 1, 9, 0, 0, 9, 0, 1);
        step(1, 1, 3, 1, 9, 0, 0, 3, 0, 1);
        step(0, 0, 0, 1, 9, 0, 1, 3, 0, 0);

        // max_val lowered below q while counting up
        step(0, 1, 8, 1, 9, 0, 0, 8, 0, 0);
        step(1, 0, 0, 1, 5, 0, 0, 0, 1, 0);
        step(0, 1, 8, 1, 9, 0, 0, 8, 0, 0);
        step(1, 0, 0, 1, 5, 1, 0, 5, 1, 1);

        // async clear mid-count with ce and load active, ovf previously set
        step(0, 1, 7, 1, 9, 0, 0, 7, 0, 1);
        @(negedge clk);
        ce = 1'b1; load = 1'b1; d = 4'd3; dir = 1'b1; max_val = 4'd9; sat = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        check_now("async_clr", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_now("clr_held", 4'd0, 1'b0, 1'b0);
        clr = 1'b0;
        load = 1'b0;
        @(posedge clk);
        #1;
        check_now("clr_release", 4'd1, 1'b0, 1'b0);

        // max_val = 0: every enabled count is a boundary event
        step(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // set beats clear on the same edge
        step(1, 0, 0, 0, 0, 1, 1, 0, 1, 1);
        step(1, 0, 0, 1, 0, 1, 1, 0, 1, 1);
        step(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);

        // drain the scoreboard with a bounded wait
        begin : drain
            int budget;
            budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised successor to the team's 4-bit async-clear up counter with count enable. It adds:
- configurable width
- runtime modulus (terminal value)
- up/down direction
- synchronous parallel load
- wrap or saturate mode
- a registered terminal-count pulse
- a sticky overflow flag with its own clear

It is the general-purpose counter for timers, dividers and address generators across the design.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- RESET_VAL, 0, value of q after clr; must be ≤ 2**WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- ce  in  1  count enable.
- load  in  1  synchronous load strobe.
- d  in  WIDTH  load value.
- dir  in  1  1 = count up, 0 = count down.
- max_val  in  WIDTH  terminal value; counting range is 0..max_val.
- sat  in  1  1 = saturate at boundary, 0 = wrap.
- ovf_clr  in  1  synchronous clear of ovf.
- q  out  WIDTH  current count (registered).
- tc  out  1  registered one-cycle pulse, high in the cycle after a boundary event.
- ovf  out  1  sticky flag; set on any boundary event while sat=1.

Behaviour:
- Reset: clr high asynchronously forces q=RESET_VAL, tc=0, ovf=0. This holds for as long as clr is high, overrides everything, and may occur mid-count. The first count happens on the first rising clk edge after clr falls, if ce=1.
- Priority per edge: clr > load > ce. load=1 updates q regardless of ce.
- Load: q <= min(d, max_val). A load never raises tc or ovf.
- Boundary (terminal) condition:
  - up: q ≥ max_val. The "≥" covers max_val having been lowered below q at runtime.
  - down: q == 0.
- Count, ce=1, load=0, not at boundary: q <= q+1 (up) or q-1 (down).
- Count at boundary ("boundary event"):
  - wrap mode (sat=0): up → q <= 0; down → q <= max_val.
  - saturate mode (sat=1): q is held. If q > max_val when counting up, q <= max_val.
- ce=0 and load=0: q is held. tc is 0 the next cycle.
- tc: registered. tc=1 for exactly one cycle following each edge on which a boundary event was processed. Consecutive boundary events (for example, saturate held with ce=1) give tc high on consecutive cycles.
- ovf:
  - Set on the edge after a boundary event with sat=1.
  - Cleared by ovf_clr.
  - Set wins over ovf_clr on the same edge.
  - Unaffected by load.
- max_val=0: q stays 0. Every enabled count is a boundary event in both directions.
- dir, sat and max_val are sampled each edge. Changing them mid-count takes effect on the next edge, with no glitch on q.
- Latency: q reflects a load or count one cycle after the sampling edge. tc and ovf are registered on the same edge as the q update.
- Arithmetic: unsigned WIDTH bits. No internal carry beyond WIDTH is exposed.

Decomposition:
- Shared package counter_pkg holds:
  - localparams DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - A function clamp(d, max) used by both load and runtime-max handling.
- One natural sub-module, counter_next: combinational next-state logic.
  - Inputs: q, dir, sat, max_val.
  - Outputs: q_next, boundary.
- The top level holds only the registers (q, tc, ovf) and the clr/load/ce priority logic.

Test Plan:
- WIDTH=4, max_val=9, dir=1, sat=0, ce=1 from clr release, 12 clocks → q: 1..9, 0, 1, 2; tc high only in the cycle after q 9→0; ovf=0.
- dir=0, max_val=5, sat=0, start q=0 → q 5, 4, 3; tc pulse after the 0→5 wrap; then sat=1, count down to 0 → q holds 0, tc high every enabled cycle, ovf=1 stays set until ovf_clr, then 0.
- load=1, d=13, max_val=9, ce=0 → q=9 next cycle; tc=0; ovf unchanged. Then load=1 with ce=1, d=3 → q=3, load wins over count.
- q=8 counting up, max_val lowered to 5 with sat=0 → next q=0 with a tc pulse. With sat=1 instead → q=5 and ovf=1.
- Assert clr asynchronously between edges at q=7, with ce and load active → q=RESET_VAL immediately, before the next edge; tc=0, ovf=0. Release clr → counting resumes from RESET_VAL on the next edge.
- max_val=0, ce=1, both directions → q stays 0, tc high every cycle. Simultaneous ovf set and ovf_clr in sat mode → ovf=1.
